// File: rtl/alarm_audio_pkg.sv
// ---------------------------------------------------------------------------
// alarm_audio_pkg
//   Shared types and constants for the alarm audio player.
//   - state_t        : player state (IDLE / SOUND / HOLD)
//   - TONE_HI/TONE_LO: encoding of the Tone_Sel output
//   - DEF_*          : default cycle counts for a 50 MHz clock
//   - PWM_W          : width of the volume threshold and PWM counter
//   - cnt_width()    : width of a counter that only ever holds 0..n-1
// ---------------------------------------------------------------------------
package alarm_audio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SOUND = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic TONE_HI = 1'b0;
  localparam logic TONE_LO = 1'b1;

  // 2 kHz / 1 kHz half periods, 250 ms segments, 500 ms tail at 50 MHz.
  localparam int DEF_HALF_HI  = 12500;
  localparam int DEF_HALF_LO  = 25000;
  localparam int DEF_SEG_CYC  = 12500000;
  localparam int DEF_HOLD_CYC = 25000000;
  localparam int DEF_WD_CYC   = 1024;

  localparam int PWM_W = 8;

  // Every counter is cleared when it reaches n-1, so $clog2(n) bits are
  // enough; a count of 1 still needs one bit to exist.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alarm_audio_player_pwm.sv
// ---------------------------------------------------------------------------
// pwm_modulator
//   Gates a 1-bit audio level with a volume PWM. An 8-bit counter runs
//   freely (cleared only by reset); the output is registered, so it lags
//   the gate input by one cycle.
//   Ports:
//     CLK   in   clock
//     RST   in   synchronous, active-low reset
//     gate  in   square wave to be gated
//     level in   duty threshold; 0 = silent, 255 = 255/256 duty
//     pwm   out  gate & (pwm_cnt < level), registered
// ---------------------------------------------------------------------------
module pwm_modulator
  import alarm_audio_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             gate,
  input  logic [PWM_W-1:0] level,
  output logic             pwm
);

  logic [PWM_W-1:0] pwm_cnt_reg;
  logic             pwm_reg;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      pwm_cnt_reg <= '0;
      pwm_reg     <= 1'b0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + PWM_W'(1);
      // Strict less-than: level 0 never asserts, level 255 misses one slot.
      pwm_reg     <= gate & (pwm_cnt_reg < level);
    end
  end

  assign pwm = pwm_reg;

endmodule

// File: rtl/alarm_audio_player.sv
// ---------------------------------------------------------------------------
// alarm_audio_player
//   Turns the alarm generator's Data level and Trig heartbeat into a
//   two-tone siren. The siren alternates between a high and a low tone
//   every SEG_CYC cycles, keeps sounding for HOLD_CYC cycles after the
//   alarm drops, and falls into HOLD with a sticky Stale flag if Trig
//   stops producing rising edges while Data is high.
//   Ports:
//     CLK       in   clock
//     RST       in   synchronous, active-low reset
//     Data      in   alarm level, 1 = alarm requested
//     Trig      in   heartbeat pulse stream
//     Volume    in   PWM duty threshold
//     Audio_Sq  out  raw siren square wave
//     Audio_PWM out  Audio_Sq gated by the volume PWM (one cycle later)
//     Active    out  1 while in SOUND or HOLD
//     Tone_Sel  out  0 = high tone, 1 = low tone
//     Stale     out  sticky: heartbeat was lost during the last alarm
//     Burst_Cnt out  IDLE->SOUND activations, saturating at 255
// ---------------------------------------------------------------------------
module alarm_audio_player
  import alarm_audio_pkg::*;
#(
  parameter int HALF_HI  = DEF_HALF_HI,
  parameter int HALF_LO  = DEF_HALF_LO,
  parameter int SEG_CYC  = DEF_SEG_CYC,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int WD_CYC   = DEF_WD_CYC
)(
  input  logic             CLK,
  input  logic             RST,
  input  logic             Data,
  input  logic             Trig,
  input  logic [PWM_W-1:0] Volume,
  output logic             Audio_Sq,
  output logic             Audio_PWM,
  output logic             Active,
  output logic             Tone_Sel,
  output logic             Stale,
  output logic [7:0]       Burst_Cnt
);

  localparam int HALF_MAX = (HALF_HI > HALF_LO) ? HALF_HI : HALF_LO;
  localparam int PH_W     = cnt_width(HALF_MAX);
  localparam int SEG_W    = cnt_width(SEG_CYC);
  localparam int HOLD_W   = cnt_width(HOLD_CYC);
  localparam int WD_W     = cnt_width(WD_CYC);

  localparam logic [PH_W-1:0]   PH_LAST_HI = PH_W'(HALF_HI - 1);
  localparam logic [PH_W-1:0]   PH_LAST_LO = PH_W'(HALF_LO - 1);
  localparam logic [SEG_W-1:0]  SEG_LAST   = SEG_W'(SEG_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYC - 1);
  localparam logic [WD_W-1:0]   WD_LAST    = WD_W'(WD_CYC - 1);

  state_t            state_reg;
  logic [PH_W-1:0]   phase_reg;
  logic [SEG_W-1:0]  seg_reg;
  logic [HOLD_W-1:0] hold_reg;
  logic [WD_W-1:0]   wd_reg;
  logic              trig_d_reg;
  logic              sq_reg;
  logic              tone_reg;
  logic              active_reg;
  logic              stale_reg;
  logic [7:0]        burst_reg;

  logic              trig_rise;
  logic [PH_W-1:0]   phase_last;

  // Next values of the tone engine, used on every edge where the siren
  // keeps running (SOUND, HOLD and the transitions between them).
  logic [PH_W-1:0]   phase_next;
  logic [SEG_W-1:0]  seg_next;
  logic              sq_next;
  logic              tone_next;

  assign trig_rise  = Trig & ~trig_d_reg;
  assign phase_last = (tone_reg == TONE_LO) ? PH_LAST_LO : PH_LAST_HI;

  always_comb begin
    phase_next = phase_reg + PH_W'(1);
    seg_next   = seg_reg + SEG_W'(1);
    sq_next    = sq_reg;
    tone_next  = tone_reg;
    if (phase_reg == phase_last) begin
      sq_next    = ~sq_reg;
      phase_next = '0;
    end
    // A segment boundary restarts the new tone from its high half and
    // wins over a half-period toggle falling on the same edge.
    if (seg_reg == SEG_LAST) begin
      tone_next  = ~tone_reg;
      seg_next   = '0;
      phase_next = '0;
      sq_next    = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg  <= IDLE;
      phase_reg  <= '0;
      seg_reg    <= '0;
      hold_reg   <= '0;
      wd_reg     <= '0;
      trig_d_reg <= 1'b0;
      sq_reg     <= 1'b0;
      tone_reg   <= TONE_HI;
      active_reg <= 1'b0;
      stale_reg  <= 1'b0;
      burst_reg  <= '0;
    end else begin
      trig_d_reg <= Trig;
      case (state_reg)
        IDLE: begin
          // A new alarm starts immediately; no heartbeat is needed yet.
          if (Data) begin
            state_reg  <= SOUND;
            active_reg <= 1'b1;
            tone_reg   <= TONE_HI;
            sq_reg     <= 1'b1;
            phase_reg  <= '0;
            seg_reg    <= '0;
            wd_reg     <= '0;
            stale_reg  <= 1'b0;
            if (burst_reg != 8'hFF) begin
              burst_reg <= burst_reg + 8'd1;
            end
          end
        end

        SOUND: begin
          phase_reg <= phase_next;
          seg_reg   <= seg_next;
          sq_reg    <= sq_next;
          tone_reg  <= tone_next;
          // Dropping Data is checked first so a normal end is never
          // reported as a lost heartbeat.
          if (!Data) begin
            state_reg <= HOLD;
            hold_reg  <= '0;
          end else if (!trig_rise && (wd_reg == WD_LAST)) begin
            state_reg <= HOLD;
            hold_reg  <= '0;
            stale_reg <= 1'b1;
          end else if (trig_rise) begin
            wd_reg <= '0;
          end else begin
            wd_reg <= wd_reg + WD_W'(1);
          end
        end

        HOLD: begin
          // Re-entry needs a fresh heartbeat edge, not just Data, and
          // takes priority over the tail running out.
          if (Data && trig_rise) begin
            state_reg <= SOUND;
            wd_reg    <= '0;
            phase_reg <= phase_next;
            seg_reg   <= seg_next;
            sq_reg    <= sq_next;
            tone_reg  <= tone_next;
          end else if (hold_reg == HOLD_LAST) begin
            state_reg  <= IDLE;
            active_reg <= 1'b0;
            sq_reg     <= 1'b0;
            tone_reg   <= TONE_HI;
            phase_reg  <= '0;
            seg_reg    <= '0;
            hold_reg   <= '0;
            wd_reg     <= '0;
          end else begin
            hold_reg  <= hold_reg + HOLD_W'(1);
            phase_reg <= phase_next;
            seg_reg   <= seg_next;
            sq_reg    <= sq_next;
            tone_reg  <= tone_next;
          end
        end

        default: begin
          state_reg  <= IDLE;
          active_reg <= 1'b0;
          sq_reg     <= 1'b0;
          tone_reg   <= TONE_HI;
        end
      endcase
    end
  end

  pwm_modulator u_pwm (
    .CLK   (CLK),
    .RST   (RST),
    .gate  (sq_reg),
    .level (Volume),
    .pwm   (Audio_PWM)
  );

  assign Audio_Sq  = sq_reg;
  assign Active    = active_reg;
  assign Tone_Sel  = tone_reg;
  assign Stale     = stale_reg;
  assign Burst_Cnt = burst_reg;

endmodule

// File: doc/alarm_audio_player.md
Name: alarm_audio_player

Overview:
- Consumer end of the alarm audio interface: takes the Data level and Trig heartbeat pulse stream and turns them into an audible two-tone siren.
- Outputs a raw square wave plus a volume-scaled PWM bitstream for the speaker / DAC filter.
- Adds a post-alarm hold tail and a liveness watchdog on Trig.
- Sits between the alarm sound generator and the audio output pin; same clock domain, no synchronisers.

Parameters:
HALF_HI, 12500, half-period of high tone in CLK cycles (2 kHz at 50 MHz); >=1
HALF_LO, 25000, half-period of low tone in CLK cycles (1 kHz); >=1
SEG_CYC, 12500000, cycles per tone segment before switching tone (250 ms); >=1
HOLD_CYC, 25000000, cycles the siren continues after alarm drops (500 ms); >=1
WD_CYC, 1024, max cycles without a Trig rising edge while Data=1 before alarm is declared stale; >=2

Ports:
CLK  in  1  clock
RST  in  1  reset; synchronous, active-low
Data  in  1  alarm level from generator; 1 = alarm requested
Trig  in  1  heartbeat pulse stream from generator (toggles while alarm active)
Volume  in  8  PWM duty threshold
Audio_Sq  out  1  raw siren square wave
Audio_PWM  out  1  Audio_Sq gated by volume PWM
Active  out  1  1 in SOUND or HOLD
Tone_Sel  out  1  0 = high tone, 1 = low tone
Stale  out  1  sticky: alarm lost heartbeat
Burst_Cnt  out  8  count of IDLE->SOUND activations, saturating at 255

Behaviour:
- Reset (RST=0 at a CLK edge): state IDLE; all outputs 0; all internal counters 0; trig_d=0. Reset mid-sound silences the outputs on that edge.
- Rising edge detect: trig_rise = Trig & ~trig_d. trig_d is registered every cycle.
- IDLE:
  - Outputs 0.
  - If Data=1, go to SOUND on the same edge (Trig not required):
    - Active=1, Tone_Sel=0, Audio_Sq=1.
    - phase, seg and wd counters cleared.
    - Stale cleared; Burst_Cnt+1 (saturating).
  - Latency Data->Active is 1 edge.
- Tone engine (SOUND and HOLD):
  - phase counter increments each cycle.
  - When phase == HALF-1 (HALF selected by Tone_Sel): Audio_Sq toggles and phase clears.
  - seg counter increments each cycle. When seg == SEG_CYC-1: Tone_Sel flips, seg=0, phase=0, Audio_Sq=1. This segment reset overrides the half-period toggle on the same edge.
- SOUND:
  - wd counter clears on trig_rise, otherwise increments.
  - If Data=0, go to HOLD; hold counter cleared.
  - Else if wd == WD_CYC-1 without trig_rise, go to HOLD and set Stale=1.
  - Data=0 has priority over the watchdog. The tone pattern is not restarted.
- HOLD:
  - Tone engine continues; hold counter increments.
  - If Data=1 and trig_rise, go to SOUND: wd cleared, tone pattern continues, Burst_Cnt unchanged, Stale unchanged.
  - Else if hold == HOLD_CYC-1, go to IDLE: outputs 0, counters cleared.
  - Re-entry to SOUND has priority over expiry on the same edge.
- PWM:
  - 8-bit free-running pwm_cnt, cleared only by reset.
  - Audio_PWM registered as Audio_Sq & (pwm_cnt < Volume).
  - Volume=0 gives Audio_PWM always 0; Volume=255 gives 255/256 duty.
  - Audio_PWM lags Audio_Sq by one cycle.
- Counter widths: $clog2 of each parameter. There are no wrap-around paths; every counter is cleared on compare.

Decomposition:
- Package alarm_audio_pkg: state enum {IDLE, SOUND, HOLD}; tone select constants TONE_HI=0, TONE_LO=1; default cycle constants at 50 MHz.
- One sub-module, pwm_modulator: holds the free-running pwm_cnt, compare and output register; inputs gate and level, output pwm.

Test Plan (bench parameters HALF_HI=4, HALF_LO=8, SEG_CYC=32, HOLD_CYC=20, WD_CYC=16):
1. RST=0 for 3 cycles with Data=1, Trig toggling -> all outputs 0, Burst_Cnt=0. Release -> Active=1 one edge later, Burst_Cnt=1.
2. Data=1, Trig alternating 1/0 every cycle, Volume=255 -> Audio_Sq period 8 for 32 cycles. Then Tone_Sel=1 with period 16 for 32 cycles, then back to Tone_Sel=0. Stale stays 0.
3. Data drops during SOUND -> Active stays 1 and the tone continues 20 cycles, then Active=0, Audio_Sq=0. Repeat with Data=1 plus a Trig edge at hold cycle 10 -> back to SOUND, Tone_Sel/phase continuous, Burst_Cnt unchanged.
4. Data=1 with Trig stuck 0 -> after 16 cycles in SOUND: HOLD, Stale=1. IDLE 20 cycles later. Next activation clears Stale.
5. Volume=0 -> Audio_PWM=0 throughout. Volume=128 with Audio_Sq held high -> Audio_PWM high 128 of every 256 cycles.
6. 260 activations (Data pulses separated by full HOLD expiry) -> Burst_Cnt saturates at 255.
